alu_arb_ctrl: RTL and testbench
===============================

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 16, operand/result width; FUN_WIDTH, 4, ALU function code width; TIMEOUT, 8, maximum cycles spent in WAIT for ALU_OUT_VLD.
REQ-002 Design SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, single clock, rising edge.
- RST, in, 1, synchronous active-high reset.
- R0_A / R0_B, in, DATA_WIDTH, requester 0 operands.
- R0_FUN, in, FUN_WIDTH, requester 0 function.
- R0_VLD, in, 1, requester 0 command valid.
- R0_RDY, out, 1, requester 0 command accepted.
- R1_A, R1_B, R1_FUN, R1_VLD, R1_RDY: same as R0_*, for requester 1.
- ALU_A / ALU_B, out, DATA_WIDTH, operands to shared ALU.
- ALU_FUN, out, FUN_WIDTH, function to ALU.
- ALU_EN, out, 1, one-cycle launch strobe.
- ALU_OUT, in, DATA_WIDTH, ALU result.
- ALU_FLAGS, in, 4, {Arith, Logic, CMP, Shift} flags.
- ALU_OUT_VLD, in, 1, result valid.
- RSP_DATA, out, DATA_WIDTH, returned result.
- RSP_FLAGS, out, 4, returned flags.
- RSP_ID, out, 1, requester that issued the command.
- RSP_ERR, out, 1, timeout indication.
- RSP_VLD, out, 1, response valid.
- RSP_RDY, in, 1, response consumer ready.

Function
REQ-004 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; only one command in flight.
REQ-005 In IDLE, grant SHALL go to the sole valid requester; if both valid, grant SHALL go to the requester named by priority pointer PRI.
REQ-006 Rx_RDY SHALL be combinational: high only in IDLE for the granted requester; both low in all other states.
REQ-007 On Rx_VLD&Rx_RDY the block SHALL latch A, B, FUN and ID, set PRI to the other requester, and enter ISSUE.
REQ-008 In ISSUE, ALU_EN SHALL be 1 for exactly one cycle with ALU_A/B/FUN = latched values; next state SHALL be WAIT.
REQ-009 ALU_A/B/FUN SHALL hold latched values from ISSUE until leaving WAIT; ALU_EN SHALL be 0 outside ISSUE.
REQ-010 In WAIT, a cycle counter starting at 0 SHALL increment each cycle.
- On ALU_OUT_VLD=1: capture ALU_OUT and ALU_FLAGS into RSP_DATA/RSP_FLAGS, set RSP_ERR=0, go to RESP.
- If counter reaches TIMEOUT-1 without ALU_OUT_VLD: set RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=1, go to RESP.
- If ALU_OUT_VLD arrives on the counter's last cycle, the valid result SHALL win.
REQ-011 ALU_OUT_VLD SHALL be ignored in IDLE, ISSUE and RESP.
REQ-012 In RESP, RSP_VLD=1 and RSP_DATA/FLAGS/ID/ERR SHALL be stable until RSP_RDY=1; on RSP_VLD&RSP_RDY go to IDLE, RSP_VLD=0 next cycle.
REQ-013 Minimum command-to-response latency SHALL be 3 cycles (accept, ISSUE, WAIT with immediate ALU_OUT_VLD); back-to-back accept SHALL be possible the cycle after response handshake.
REQ-014 Requester VLD changes while not ready SHALL have no effect; no command SHALL be dropped once accepted, except by reset.

Reset
REQ-015 On RST=1 at a rising edge: state=IDLE, PRI=0, counter=0, ALU_A/B/FUN=0, ALU_EN=0, RSP_DATA/FLAGS/ID/ERR=0, RSP_VLD=0.
REQ-016 Reset mid-operation (ISSUE/WAIT/RESP) SHALL abandon the in-flight command with no response; a late ALU_OUT_VLD after reset SHALL be ignored.
REQ-017 While RST=1, R0_RDY and R1_RDY SHALL be 0.

Structure
REQ-018 FSM state encoding and the flag bit positions SHALL live in shared package alu_ctrl_pkg.
REQ-019 Round-robin grant logic SHALL be sub-module rr_arb2 (inputs: two valids, PRI; output: one-hot grant); rest is flat.

Verification
REQ-020 The bench SHALL use an ALU model with 1-cycle latency and a mode that suppresses ALU_OUT_VLD.
REQ-021 Directed scenarios the bench SHALL cover:
- Single: R0 A=16, B=4, FUN=0000 (add) -> RSP_DATA=20, ID=0, ERR=0, RSP_VLD 3 cycles after accept.
- Contention: R0 and R1 both valid after reset -> R0 served first, then R1 (A=16, B=4, FUN=0001 -> 12, ID=1); third joint request -> R0.
- Backpressure: RSP_RDY=0 for 5 cycles -> RSP_* stable, R0_RDY=R1_RDY=0 throughout.
- Timeout: ALU_OUT_VLD suppressed -> RESP after 8 WAIT cycles, RSP_ERR=1, RSP_DATA=0.
- Reset in WAIT: RST pulse -> RSP_VLD stays 0, PRI=0, next R1 command accepted and correct.
- Spurious: ALU_OUT_VLD pulsed in IDLE -> no RSP_VLD.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbitration controller: FSM state
// encoding, the ALU flag layout and small helpers.
package alu_ctrl_pkg;

    // Controller FSM states; only one command is ever in flight.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // ALU flag vector, MSB first: {Arith, Logic, CMP, Shift}.
    typedef struct packed {
        logic arith;
        logic logic_op;
        logic cmp;
        logic shift;
    } alu_flags_t;

    // Requester that gets priority after the given one is served.
    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/alu_arb_ctrl_rr_arb2.sv
// Two-requester round-robin grant: a lone valid requester always wins,
// on contention the priority pointer picks the winner. Grant is one-hot
// or all-zero when nobody is valid.
module rr_arb2 (
    input  logic       vld0,
    input  logic       vld1,
    input  logic       pri,
    output logic [1:0] gnt
);

    // Grant decode from the two valids and the priority pointer.
    always_comb begin
        gnt = 2'b00;
        if (vld0 && vld1) begin
            gnt = pri ? 2'b10 : 2'b01;
        end else if (vld0) begin
            gnt = 2'b01;
        end else if (vld1) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Arbitrates two command requesters onto one shared ALU. A command is
// latched, launched with a one-cycle strobe, its result (or a timeout
// error) is held on the response port until the consumer takes it.
module alu_arb_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] R0_A,
    input  logic [DATA_WIDTH-1:0] R0_B,
    input  logic [FUN_WIDTH-1:0]  R0_FUN,
    input  logic                  R0_VLD,
    output logic                  R0_RDY,
    input  logic [DATA_WIDTH-1:0] R1_A,
    input  logic [DATA_WIDTH-1:0] R1_B,
    input  logic [FUN_WIDTH-1:0]  R1_FUN,
    input  logic                  R1_VLD,
    output logic                  R1_RDY,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic [3:0]            ALU_FLAGS,
    input  logic                  ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic [3:0]            RSP_FLAGS,
    output logic                  RSP_ID,
    output logic                  RSP_ERR,
    output logic                  RSP_VLD,
    input  logic                  RSP_RDY
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    state_e                state_r, state_s;
    logic                  pri_r, pri_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [DATA_WIDTH-1:0] alu_a_r, alu_a_s;
    logic [DATA_WIDTH-1:0] alu_b_r, alu_b_s;
    logic [FUN_WIDTH-1:0]  alu_fun_r, alu_fun_s;
    logic                  alu_en_r, alu_en_s;
    logic                  cmd_id_r, cmd_id_s;
    logic [DATA_WIDTH-1:0] rsp_data_r, rsp_data_s;
    alu_flags_t            rsp_flags_r, rsp_flags_s;
    logic                  rsp_id_r, rsp_id_s;
    logic                  rsp_err_r, rsp_err_s;
    logic                  rsp_vld_r, rsp_vld_s;
    logic [1:0]            gnt_s;
    logic                  acc0_s, acc1_s;

    rr_arb2 u_arb (
        .vld0 (R0_VLD),
        .vld1 (R1_VLD),
        .pri  (pri_r),
        .gnt  (gnt_s)
    );

    // Ready is offered only in IDLE, only to the granted requester, never in reset.
    always_comb begin
        R0_RDY = 1'b0;
        R1_RDY = 1'b0;
        if (!RST && (state_r == ST_IDLE)) begin
            R0_RDY = gnt_s[0];
            R1_RDY = gnt_s[1];
        end else begin
            R0_RDY = 1'b0;
            R1_RDY = 1'b0;
        end
    end

    assign acc0_s = R0_VLD & R0_RDY;
    assign acc1_s = R1_VLD & R1_RDY;

    // Next-state and next-register values; everything holds unless changed.
    always_comb begin
        state_s     = state_r;
        pri_s       = pri_r;
        cnt_s       = cnt_r;
        alu_a_s     = alu_a_r;
        alu_b_s     = alu_b_r;
        alu_fun_s   = alu_fun_r;
        alu_en_s    = 1'b0;
        cmd_id_s    = cmd_id_r;
        rsp_data_s  = rsp_data_r;
        rsp_flags_s = rsp_flags_r;
        rsp_id_s    = rsp_id_r;
        rsp_err_s   = rsp_err_r;
        rsp_vld_s   = rsp_vld_r;
        case (state_r)
            ST_IDLE: begin
                if (acc0_s) begin
                    alu_a_s   = R0_A;
                    alu_b_s   = R0_B;
                    alu_fun_s = R0_FUN;
                    cmd_id_s  = 1'b0;
                    pri_s     = other_id(1'b0);
                    alu_en_s  = 1'b1;
                    state_s   = ST_ISSUE;
                end else if (acc1_s) begin
                    alu_a_s   = R1_A;
                    alu_b_s   = R1_B;
                    alu_fun_s = R1_FUN;
                    cmd_id_s  = 1'b1;
                    pri_s     = other_id(1'b1);
                    alu_en_s  = 1'b1;
                    state_s   = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_s   = '0;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the final count still beats the timeout.
                if (ALU_OUT_VLD) begin
                    rsp_data_s  = ALU_OUT;
                    rsp_flags_s = alu_flags_t'(ALU_FLAGS);
                    rsp_err_s   = 1'b0;
                    rsp_id_s    = cmd_id_r;
                    rsp_vld_s   = 1'b1;
                    state_s     = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    rsp_data_s  = '0;
                    rsp_flags_s = '0;
                    rsp_err_s   = 1'b1;
                    rsp_id_s    = cmd_id_r;
                    rsp_vld_s   = 1'b1;
                    state_s     = ST_RESP;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RESP: begin
                if (RSP_RDY) begin
                    rsp_vld_s = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; reset abandons any in-flight command.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pri_r       <= 1'b0;
            cnt_r       <= '0;
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            alu_fun_r   <= '0;
            alu_en_r    <= 1'b0;
            cmd_id_r    <= 1'b0;
            rsp_data_r  <= '0;
            rsp_flags_r <= '0;
            rsp_id_r    <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_vld_r   <= 1'b0;
        end else begin
            pri_r       <= pri_s;
            cnt_r       <= cnt_s;
            alu_a_r     <= alu_a_s;
            alu_b_r     <= alu_b_s;
            alu_fun_r   <= alu_fun_s;
            alu_en_r    <= alu_en_s;
            cmd_id_r    <= cmd_id_s;
            rsp_data_r  <= rsp_data_s;
            rsp_flags_r <= rsp_flags_s;
            rsp_id_r    <= rsp_id_s;
            rsp_err_r   <= rsp_err_s;
            rsp_vld_r   <= rsp_vld_s;
        end
    end

    assign ALU_A     = alu_a_r;
    assign ALU_B     = alu_b_r;
    assign ALU_FUN   = alu_fun_r;
    assign ALU_EN    = alu_en_r;
    assign RSP_DATA  = rsp_data_r;
    assign RSP_FLAGS = rsp_flags_r;
    assign RSP_ID    = rsp_id_r;
    assign RSP_ERR   = rsp_err_r;
    assign RSP_VLD   = rsp_vld_r;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed bench for alu_arb_ctrl with a 1-cycle ALU model that can
// suppress its valid, plus a directly driven stray valid pulse.
module tb_alu_arb_ctrl;

    localparam int DW = 16;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [FW-1:0] r0_fun, r1_fun;
    logic          r0_vld, r0_rdy, r1_vld, r1_rdy;
    logic [DW-1:0] alu_a, alu_b;
    logic [FW-1:0] alu_fun;
    logic          alu_en;
    logic [DW-1:0] alu_out = 16'd0;
    logic [3:0]    alu_flags = 4'b0000;
    logic          mdl_vld = 1'b0;
    logic          spur, suppress;
    logic          alu_out_vld;
    logic [DW-1:0] rsp_data;
    logic [3:0]    rsp_flags;
    logic          rsp_id, rsp_err, rsp_vld, rsp_rdy;

    int errors = 0;
    int checks = 0;
    int n;

    assign alu_out_vld = mdl_vld | spur;

    alu_arb_ctrl #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .TIMEOUT(8)) dut (
        .CLK(clk), .RST(rst),
        .R0_A(r0_a), .R0_B(r0_b), .R0_FUN(r0_fun), .R0_VLD(r0_vld), .R0_RDY(r0_rdy),
        .R1_A(r1_a), .R1_B(r1_b), .R1_FUN(r1_fun), .R1_VLD(r1_vld), .R1_RDY(r1_rdy),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun), .ALU_EN(alu_en),
        .ALU_OUT(alu_out), .ALU_FLAGS(alu_flags), .ALU_OUT_VLD(alu_out_vld),
        .RSP_DATA(rsp_data), .RSP_FLAGS(rsp_flags), .RSP_ID(rsp_id),
        .RSP_ERR(rsp_err), .RSP_VLD(rsp_vld), .RSP_RDY(rsp_rdy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // ALU model: result and valid one cycle after the launch strobe.
    always @(posedge clk) begin
        mdl_vld <= alu_en & ~suppress;
        if (alu_en) begin
            case (alu_fun)
                4'd0:    begin alu_out <= alu_a + alu_b; alu_flags <= 4'b1000; end
                4'd1:    begin alu_out <= alu_a - alu_b; alu_flags <= 4'b1000; end
                4'd2:    begin alu_out <= alu_a & alu_b; alu_flags <= 4'b0100; end
                4'd3:    begin alu_out <= alu_a | alu_b; alu_flags <= 4'b0100; end
                default: begin alu_out <= 16'd0;         alu_flags <= 4'b0000; end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_r0(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [FW-1:0] f);
        r0_a = a; r0_b = b; r0_fun = f;
    endtask

    task automatic set_r1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [FW-1:0] f);
        r1_a = a; r1_b = b; r1_fun = f;
    endtask

    initial begin
        rst = 1'b1; rsp_rdy = 1'b1; spur = 1'b0; suppress = 1'b0;
        r0_vld = 1'b0; r1_vld = 1'b0;
        set_r0(16'd0, 16'd0, 4'd0);
        set_r1(16'd0, 16'd0, 4'd0);
        step(); step();

        // Reset state and ready suppression while reset is high
        r0_vld = 1'b1; r1_vld = 1'b1; #1;
        chk("rst_r0_rdy", r0_rdy, 32'd0);
        chk("rst_r1_rdy", r1_rdy, 32'd0);
        chk("rst_alu_en", alu_en, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_fun", alu_fun, 32'd0);
        chk("rst_rsp_vld", rsp_vld, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", rsp_err, 32'd0);
        chk("rst_rsp_flags", rsp_flags, 32'd0);
        r0_vld = 1'b0; r1_vld = 1'b0; rst = 1'b0;
        step();

        // Single R0 add: 16+4=20, response 3 cycles after accept
        set_r0(16'd16, 16'd4, 4'd0); r0_vld = 1'b1; #1;
        chk("single_r0_rdy", r0_rdy, 32'd1);
        chk("single_r1_rdy", r1_rdy, 32'd0);
        step();
        chk("issue_r0_rdy", r0_rdy, 32'd0);
        r0_vld = 1'b0;
        chk("issue_alu_en", alu_en, 32'd1);
        chk("issue_alu_a", alu_a, 32'd16);
        chk("issue_alu_b", alu_b, 32'd4);
        chk("issue_alu_fun", alu_fun, 32'd0);
        step();
        chk("wait_alu_en", alu_en, 32'd0);
        chk("wait_alu_a_hold", alu_a, 32'd16);
        chk("wait_rsp_vld", rsp_vld, 32'd0);
        step();
        chk("single_rsp_vld", rsp_vld, 32'd1);
        chk("single_rsp_data", rsp_data, 32'd20);
        chk("single_rsp_id", rsp_id, 32'd0);
        chk("single_rsp_err", rsp_err, 32'd0);
        chk("single_rsp_flags", rsp_flags, 32'd8);
        step();
        chk("single_rsp_drop", rsp_vld, 32'd0);

        // Contention straight after reset: R0, then R1, then R0 again
        rst = 1'b1; step(); rst = 1'b0;
        set_r0(16'd16, 16'd4, 4'd0); set_r1(16'd16, 16'd4, 4'd1);
        r0_vld = 1'b1; r1_vld = 1'b1; #1;
        chk("cont1_r0_rdy", r0_rdy, 32'd1);
        chk("cont1_r1_rdy", r1_rdy, 32'd0);
        step(); r0_vld = 1'b0;
        step(); step();
        chk("cont1_rsp_data", rsp_data, 32'd20);
        chk("cont1_rsp_id", rsp_id, 32'd0);
        step();
        chk("cont2_b2b_r1_rdy", r1_rdy, 32'd1);
        step(); r1_vld = 1'b0;
        chk("cont2_alu_fun", alu_fun, 32'd1);
        step(); step();
        chk("cont2_rsp_vld", rsp_vld, 32'd1);
        chk("cont2_rsp_data", rsp_data, 32'd12);
        chk("cont2_rsp_id", rsp_id, 32'd1);
        step();
        set_r0(16'd7, 16'd9, 4'd2); set_r1(16'd3, 16'd3, 4'd3);
        r0_vld = 1'b1; r1_vld = 1'b1; #1;
        chk("cont3_r0_rdy", r0_rdy, 32'd1);
        chk("cont3_r1_rdy", r1_rdy, 32'd0);
        step(); r0_vld = 1'b0; r1_vld = 1'b0;
        step(); step();
        chk("cont3_rsp_data", rsp_data, 32'd1);
        chk("cont3_rsp_id", rsp_id, 32'd0);
        chk("cont3_rsp_flags", rsp_flags, 32'd4);
        step();

        // Backpressure: 100-3=97 held for 5 cycles, no ready offered
        rsp_rdy = 1'b0;
        set_r0(16'd100, 16'd3, 4'd1); r0_vld = 1'b1;
        step(); r0_vld = 1'b0;
        step(); step();
        set_r0(16'd55, 16'd1, 4'd0); set_r1(16'd66, 16'd2, 4'd0);
        r0_vld = 1'b1; r1_vld = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_vld", rsp_vld, 32'd1);
            chk("bp_rsp_data", rsp_data, 32'd97);
            chk("bp_rsp_id", rsp_id, 32'd0);
            chk("bp_r0_rdy", r0_rdy, 32'd0);
            chk("bp_r1_rdy", r1_rdy, 32'd0);
            step();
        end
        rsp_rdy = 1'b1;
        step(); #1;
        chk("bp_release_vld", rsp_vld, 32'd0);
        chk("bp_release_r1_rdy", r1_rdy, 32'd1);
        chk("bp_release_r0_rdy", r0_rdy, 32'd0);
        r0_vld = 1'b0; r1_vld = 1'b0;
        step();

        // Timeout: no ALU valid, response after 8 WAIT cycles with error
        suppress = 1'b1;
        set_r0(16'd5, 16'd5, 4'd0); r0_vld = 1'b1;
        step(); r0_vld = 1'b0;
        step();
        n = 0;
        while (rsp_vld !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("to_wait_cycles", n, 32'd8);
        chk("to_rsp_err", rsp_err, 32'd1);
        chk("to_rsp_data", rsp_data, 32'd0);
        chk("to_rsp_flags", rsp_flags, 32'd0);
        step();
        chk("to_rsp_drop", rsp_vld, 32'd0);

        // Result on the last WAIT cycle beats the timeout: 50+8=58
        set_r0(16'd50, 16'd8, 4'd0); r0_vld = 1'b1;
        step(); r0_vld = 1'b0;
        step();
        repeat (7) step();
        chk("last_pre_vld", rsp_vld, 32'd0);
        spur = 1'b1;
        step(); spur = 1'b0;
        chk("last_rsp_vld", rsp_vld, 32'd1);
        chk("last_rsp_data", rsp_data, 32'd58);
        chk("last_rsp_err", rsp_err, 32'd0);
        step();

        // Reset in WAIT, late ALU valid afterwards, then an R1 command
        set_r0(16'd1, 16'd2, 4'd0); r0_vld = 1'b1;
        step(); r0_vld = 1'b0;
        step(); step();
        rst = 1'b1;
        step(); rst = 1'b0; spur = 1'b1;
        chk("rw_alu_a", alu_a, 32'd0);
        chk("rw_alu_en", alu_en, 32'd0);
        chk("rw_rsp_vld0", rsp_vld, 32'd0);
        step(); spur = 1'b0;
        chk("rw_rsp_vld1", rsp_vld, 32'd0);
        step();
        chk("rw_rsp_vld2", rsp_vld, 32'd0);
        suppress = 1'b0;
        set_r1(16'd30, 16'd12, 4'd1);
        r0_vld = 1'b1; r1_vld = 1'b1; #1;
        chk("rw_pri0_r0_rdy", r0_rdy, 32'd1);
        chk("rw_pri0_r1_rdy", r1_rdy, 32'd0);
        r0_vld = 1'b0; #1;
        chk("rw_r1_rdy", r1_rdy, 32'd1);
        step(); r1_vld = 1'b0;
        step(); step();
        chk("rw_rsp_vld", rsp_vld, 32'd1);
        chk("rw_rsp_data", rsp_data, 32'd18);
        chk("rw_rsp_id", rsp_id, 32'd1);
        chk("rw_rsp_err", rsp_err, 32'd0);
        step();

        // Stray ALU valid in IDLE produces nothing
        spur = 1'b1;
        step(); spur = 1'b0;
        chk("spur_rsp_vld0", rsp_vld, 32'd0);
        step();
        chk("spur_rsp_vld1", rsp_vld, 32'd0);
        r0_vld = 1'b1; #1;
        chk("spur_idle_r0_rdy", r0_rdy, 32'd1);
        r0_vld = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
